// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmitter and the future receiver
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic int timer_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter emitting a one-cycle bit_end tick
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLK_CY_PER_BIT = 87
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int W = timer_width(CLK_CY_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLK_CY_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign bit_end = enable && !clear && (cnt == LAST);

  // Wraps on its own at bit_end so consecutive bits need no explicit clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= bit_end ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter; UART_TX_BREAK_EN adds line-break generation
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_CY_PER_BIT = 87,
  parameter int DATA_BITS      = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
`ifdef UART_TX_BREAK_EN
  input  logic                 i_Break,
`endif
  input  logic                 i_Tx_Dv,
  input  logic [DATA_BITS-1:0] i_Tx_Data,
  input  logic [1:0]           i_Parity_Mode,
  input  logic                 i_Two_Stop,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done,
  output logic                 o_Tx_Serial
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 two_stop_q, two_stop_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 mark_q, mark_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;

  logic bit_end, brk_in, frame_end, can_start, accept, brk_go;
  logic timer_clear, timer_en;

`ifdef UART_TX_BREAK_EN
  assign brk_in = i_Break;
`else
  assign brk_in = 1'b0;
`endif

  // The last cycle of the final stop bit also accepts, giving gap-free frames.
  assign frame_end  = (state_q == STOP) && bit_end && (!two_stop_q || stop_cnt_q);
  assign can_start  = (state_q == IDLE) || frame_end;
  assign o_Tx_Ready = can_start && !brk_in;
  assign accept     = o_Tx_Ready && i_Tx_Dv;
  assign brk_go     = can_start && brk_in;

  assign timer_clear = i_rst || (state_q == IDLE) || ((state_q == BREAK) && !mark_q);
  assign timer_en    = (state_q != IDLE);

  uart_bit_timer #(
    .CLK_CY_PER_BIT(CLK_CY_PER_BIT)
  ) u_timer (
    .clk    (i_clk),
    .clear  (timer_clear),
    .enable (timer_en),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    two_stop_d = two_stop_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    mark_d     = mark_q;
    serial_d   = serial_q;
    active_d   = active_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          serial_d  = shift_q[0];
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (par_en_q) begin
              state_d  = PARITY;
              serial_d = par_bit_q;
            end else begin
              state_d    = STOP;
              serial_d   = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            shift_d   = shift_q >> 1;
            serial_d  = shift_q[1];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          serial_d   = 1'b1;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (frame_end) begin
          state_d  = IDLE;
          serial_d = 1'b1;
          active_d = 1'b0;
          done_d   = 1'b1;
        end else if (bit_end) begin
          stop_cnt_d = 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        if (!mark_q) begin
          serial_d = 1'b0;
          if (!brk_in) begin
            mark_d   = 1'b1;
            serial_d = 1'b1;
          end
        end else if (bit_end) begin
          state_d  = IDLE;
          mark_d   = 1'b0;
          active_d = 1'b0;
          serial_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
        active_d = 1'b0;
      end
    endcase

    if (brk_go) begin
      state_d  = BREAK;
      mark_d   = 1'b0;
      serial_d = 1'b0;
      active_d = 1'b1;
    end else if (accept) begin
      state_d    = START;
      serial_d   = 1'b0;
      active_d   = 1'b1;
      shift_d    = i_Tx_Data;
      two_stop_d = i_Two_Stop;
      case (i_Parity_Mode)
        PAR_EVEN: begin
          par_en_d  = 1'b1;
          par_bit_d = ^i_Tx_Data;
        end
        PAR_ODD: begin
          par_en_d  = 1'b1;
          par_bit_d = ~^i_Tx_Data;
        end
        default: begin
          par_en_d  = 1'b0;
          par_bit_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      two_stop_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      mark_q     <= 1'b0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      two_stop_q <= two_stop_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      mark_q     <= mark_d;
      serial_q   <= serial_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - self-checking bench for uart_tx_cfg (8- and 7-bit instances, optional UART_TX_BREAK_EN)
module tb_uart_tx_cfg;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst, dv, two, brk;
  logic [8:0] data;
  logic [1:0] mode;
  logic       started = 1'b0;

  int errors = 0;
  int checks = 0;

  logic w0 [0:127];
  logic w1 [0:127];
  int   act_n [2];
  int   done_n [2];
  int   done_at [2];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int DB = (g == 0) ? 8 : 7;
    logic [DB-1:0] d_in;
    logic ser, act, rdy, dn;
    assign d_in = data[DB-1:0];

    uart_tx_cfg #(.CLK_CY_PER_BIT(N), .DATA_BITS(DB)) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
`ifdef UART_TX_BREAK_EN
      .i_Break      (brk),
`endif
      .i_Tx_Dv      (dv),
      .i_Tx_Data    (d_in),
      .i_Parity_Mode(mode),
      .i_Two_Stop   (two),
      .o_Tx_Ready   (rdy),
      .o_Tx_Active  (act),
      .o_Tx_Done    (dn),
      .o_Tx_Serial  (ser)
    );

    // Model: a queue of line levels still to be sent, one entry per clock.
    logic mq [$];
    logic m_done = 1'b0;
    logic m_brk  = 1'b0;
    int   m_mark = 0;

    task automatic push_bit(input logic b);
      for (int k = 0; k < N; k++) mq.push_back(b);
    endtask

    task automatic push_frame();
      int ones;
      ones = 0;
      push_bit(1'b0);
      for (int i = 0; i < DB; i++) begin
        ones += int'(data[i]);
        push_bit(data[i]);
      end
      if (mode == 2'b01) push_bit(ones % 2 == 1);
      if (mode == 2'b10) push_bit(ones % 2 == 0);
      push_bit(1'b1);
      if (two) push_bit(1'b1);
    endtask

    task automatic step();
      int sz;
      bit go_brk, go_frm;
      sz = mq.size();
      if (rst) begin
        mq.delete();
        m_done <= 1'b0;
        m_brk  <= 1'b0;
        m_mark <= 0;
      end else begin
        m_done <= (sz == 1);
        if (sz > 0) void'(mq.pop_front());
        go_brk = !m_brk && m_mark == 0 && sz <= 1 && brk;
        go_frm = !m_brk && m_mark == 0 && sz <= 1 && !brk && dv;
        if (m_brk && !brk) begin
          m_brk  <= 1'b0;
          m_mark <= N;
        end else if (m_mark > 0) begin
          m_mark <= m_mark - 1;
        end
        if (go_brk) m_brk <= 1'b1;
        if (go_frm) push_frame();
      end
    endtask

    always @(posedge clk) step();

    always @(posedge clk) begin
      #1;
      if (started) begin
        chk($sformatf("serial_%0d", g), 32'(ser), m_brk ? 32'd0 : (mq.size() > 0 ? 32'(mq[0]) : 32'd1));
        chk($sformatf("active_%0d", g), 32'(act), 32'(m_brk || m_mark > 0 || mq.size() > 0));
        chk($sformatf("ready_%0d", g), 32'(rdy), 32'(!m_brk && m_mark == 0 && mq.size() <= 1 && !brk));
        chk($sformatf("done_%0d", g), 32'(dn), 32'(m_done));
      end
    end
  end

  task automatic capture(input int ncyc);
    for (int i = 0; i < 2; i++) begin
      act_n[i] = 0; done_n[i] = 0; done_at[i] = -1;
    end
    for (int c = 0; c < ncyc; c++) begin
      w0[c] = gi[0].ser;
      w1[c] = gi[1].ser;
      if (gi[0].act) act_n[0]++;
      if (gi[1].act) act_n[1]++;
      if (gi[0].dn) begin done_n[0]++; if (done_at[0] < 0) done_at[0] = c; end
      if (gi[1].dn) begin done_n[1]++; if (done_at[1] < 0) done_at[1] = c; end
      @(negedge clk);
    end
  endtask

  // Accept on the next edge, then scramble inputs to prove they were latched.
  task automatic send(input logic [8:0] d, input logic [1:0] m, input logic ts, input int ncyc);
    data = d; mode = m; two = ts; dv = 1'b1;
    @(negedge clk);
    dv = 1'b0; data = ~d; mode = ~m; two = ~ts;
    capture(ncyc);
  endtask

  initial begin
    logic [9:0] a5_bits;
    int low_n, rdy_at;
    a5_bits = 10'b1101001010;
    rst = 1'b1; dv = 1'b0; data = '0; mode = 2'b00; two = 1'b0; brk = 1'b0;

    @(negedge clk);
    started = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_serial", 32'(gi[0].ser), 32'd1);
    chk("rst_ready",  32'(gi[0].rdy), 32'd1);
    chk("rst_active", 32'(gi[0].act), 32'd0);
    chk("rst_done",   32'(gi[0].dn),  32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send(9'h0A5, 2'b00, 1'b0, 48);
    for (int k = 0; k < 10; k++) chk($sformatf("a5_bit%0d", k), 32'(w0[4*k+1]), 32'(a5_bits[k]));
    chk("a5_active_len", act_n[0], 40);
    chk("a5_done_at", done_at[0], 40);
    chk("a5_done_cnt", done_n[0], 1);
    chk("a5_active_len_7b", act_n[1], 36);

    send(9'h041, 2'b01, 1'b0, 48);
    chk("even_parity_7b", 32'(w1[33]), 32'd0);
    chk("even_len_7b", act_n[1], 40);
    send(9'h041, 2'b10, 1'b0, 48);
    chk("odd_parity_7b", 32'(w1[33]), 32'd1);
    send(9'h041, 2'b10, 1'b1, 52);
    chk("two_stop_len_7b", act_n[1], 44);
    chk("two_stop_done_7b", done_at[1], 44);

    data = 9'h000; mode = 2'b00; two = 1'b0; dv = 1'b1;
    @(negedge clk);
    done_n[0] = 0;
    for (int c = 0; c < 100; c++) begin
      w0[c] = gi[0].ser;
      if (gi[0].dn) done_n[0]++;
      if (c == 39) data = 9'h0FF;
      if (c == 40) dv = 1'b0;
      @(negedge clk);
    end
    chk("b2b_last_stop", 32'(w0[39]), 32'd1);
    chk("b2b_next_start", 32'(w0[40]), 32'd0);
    chk("b2b_ff_bit0", 32'(w0[45]), 32'd1);
    chk("b2b_done_cnt", done_n[0], 2);

    data = 9'h0A5; mode = 2'b00; two = 1'b0; dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_serial", 32'(gi[0].ser), 32'd1);
    chk("rst_mid_active", 32'(gi[0].act), 32'd0);
    rst = 1'b0;
    capture(60);
    chk("rst_mid_no_done", done_n[0], 0);
    send(9'h03C, 2'b00, 1'b0, 48);
    chk("fresh_start", 32'(w0[1]), 32'd0);
    chk("fresh_bit2", 32'(w0[13]), 32'd1);
    chk("fresh_len", act_n[0], 40);
    chk("fresh_done_at", done_at[0], 40);

`ifdef UART_TX_BREAK_EN
    brk = 1'b1;
    @(negedge clk);
    low_n = 0; rdy_at = -1;
    for (int c = 0; c < 40; c++) begin
      if (!gi[0].ser) low_n++;
      if (gi[0].rdy && rdy_at < 0) rdy_at = c;
      if (c == 19) brk = 1'b0;
      @(negedge clk);
    end
    chk("break_low_len", low_n, 20);
    chk("break_ready_at", rdy_at, 24);
`else
    low_n = 0; rdy_at = 0;
`endif

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
